issue_scoreboard: RTL and testbench

Issue-stage scoreboard and register-file write-port scheduler, sitting between decode and execute in the in-order pipeline. It tracks outstanding multi-cycle results (loads, FPU add/sub/inv/sqrt) for all 32 GPRs and 32 FPRs. It stalls decode on RAW/WAW hazards and reserves the single register-file write port cycle-by-cycle, so no two instructions ever write back in the same cycle.

---
 rtl/issue_scoreboard_pkg.sv | 18 +
 rtl/wb_port_reserve.sv | 19 +
 rtl/issue_scoreboard.sv | 70 +++++++
 tb/tb_issue_scoreboard.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared register tags, write classes and stall-cause encoding
package issue_scoreboard_pkg;
  typedef logic [5:0] reg_tag_t;
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;
  localparam reg_tag_t TAG_ZERO  = 6'd0;
  localparam int NUM_TAGS        = 64;
  typedef enum logic [1:0] {
    SC_NONE = 2'b00,
    SC_RAW  = 2'b01,
    SC_WAW  = 2'b10,
    SC_PORT = 2'b11
  } stall_cause_t;
  function automatic logic is_write_class(input logic [1:0] rw);
    return rw == RW_GPR || rw == RW_FPR;
  endfunction
endpackage

// File: rtl/wb_port_reserve.sv
// wb_port_reserve: cycle-by-cycle ownership of the single register-file write port
module wb_port_reserve #(
  parameter int MAXW = 31
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] i_w,
  input  logic       i_reserve,
  output logic       o_conflict
);
  logic [MAXW:0] r_resv;
  logic [MAXW:0] w_new;
  assign w_new = (i_reserve && i_w != 5'd0) ? ({{MAXW{1'b0}}, 1'b1} << (i_w - 5'd1)) : '0;
  assign o_conflict = r_resv[i_w];
  // bit k is the port at now+1+k; zero-wait writers use the next cycle and need no storage
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_resv <= '0;
    else r_resv <= (r_resv >> 1) | w_new;
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RAW/WAW hazard scoreboard and write-port scheduler for the issue stage
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAXW = 31
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dec_valid,
  input  logic [5:0]  rs,
  input  logic [5:0]  rt,
  input  logic        use_s,
  input  logic        use_t,
  input  logic [1:0]  rw,
  input  logic [4:0]  rd,
  input  logic [4:0]  wait_time,
  input  logic        hold,
  output logic        issue,
  output logic        stall,
  output logic [1:0]  stall_cause,
  output logic [63:0] busy_mask,
  output logic [31:0] stall_cycles
);
  logic [NUM_TAGS-1:0][4:0] r_cnt;
  logic [31:0]              r_stall_cycles;
  logic [NUM_TAGS-1:0]      w_busy;
  reg_tag_t                 w_dest;
  logic                     w_write;
  logic                     w_raw;
  logic                     w_waw;
  logic                     w_port;
  logic                     w_hazard;
  logic                     w_conflict;
  stall_cause_t             w_cause;
  // a tag is busy while its countdown is nonzero; tag 0 ($0) never is
  always_comb begin
    w_busy = '0;
    for (int n = 1; n < NUM_TAGS; n++) w_busy[n] = r_cnt[n] != 5'd0;
  end
  assign w_dest   = {rw == RW_FPR, rd};
  assign w_write  = dec_valid && is_write_class(rw) && w_dest != TAG_ZERO;
  assign w_raw    = (use_s && w_busy[rs]) || (use_t && w_busy[rt]);
  assign w_waw    = w_write && w_busy[w_dest];
  assign w_port   = w_write && w_conflict;
  assign w_hazard = w_raw || w_waw || w_port;
  assign w_cause  = !dec_valid ? SC_NONE : w_raw ? SC_RAW : w_waw ? SC_WAW : w_port ? SC_PORT : SC_NONE;
  assign stall        = dec_valid && w_hazard;
  assign issue        = dec_valid && !w_hazard && !hold;
  assign stall_cause  = w_cause;
  assign busy_mask    = w_busy;
  assign stall_cycles = r_stall_cycles;
  wb_port_reserve #(.MAXW(MAXW)) u_port (
    .clk        (clk),
    .rstn       (rstn),
    .i_w        (wait_time),
    .i_reserve  (issue && w_write),
    .o_conflict (w_conflict)
  );
  // load the issuing destination's countdown, let every other pending tag count down
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_cnt <= '0;
    else
      for (int n = 0; n < NUM_TAGS; n++)
        r_cnt[n] <= (issue && w_write && w_dest == reg_tag_t'(n)) ? wait_time :
                    (r_cnt[n] != 5'd0 ? r_cnt[n] - 5'd1 : 5'd0);
  // cycles in which decode was held by a hazard, wrapping at 2^32
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_stall_cycles <= '0;
    else r_stall_cycles <= r_stall_cycles + {31'd0, stall};
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed table, reset corner case and random run against an absolute-time model
module tb_issue_scoreboard;
  logic        clk = 0;
  logic        rstn = 0;
  logic        dec_valid = 0;
  logic [5:0]  rs = 0;
  logic [5:0]  rt = 0;
  logic        use_s = 0;
  logic        use_t = 0;
  logic [1:0]  rw = 0;
  logic [4:0]  rd = 0;
  logic [4:0]  wait_time = 0;
  logic        hold = 0;
  logic        issue;
  logic        stall;
  logic [1:0]  stall_cause;
  logic [63:0] busy_mask;
  logic [31:0] stall_cycles;

  issue_scoreboard dut (
    .clk          (clk),
    .rstn         (rstn),
    .dec_valid    (dec_valid),
    .rs           (rs),
    .rt           (rt),
    .use_s        (use_s),
    .use_t        (use_t),
    .rw           (rw),
    .rd           (rd),
    .wait_time    (wait_time),
    .hold         (hold),
    .issue        (issue),
    .stall        (stall),
    .stall_cause  (stall_cause),
    .busy_mask    (busy_mask),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  s;
    logic [5:0]  t;
    logic        us;
    logic        ut;
    logic [1:0]  rw;
    logic [4:0]  rd;
    logic [4:0]  w;
    logic        h;
    logic        ei;
    logic        es;
    logic [1:0]  ec;
    logic [63:0] eb;
    logic [31:0] esc;
  } vec_t;

  localparam logic [63:0] B2  = 64'h4;
  localparam logic [63:0] B35 = 64'h8_0000_0000;
  localparam logic [63:0] B36 = 64'h10_0000_0000;

  int n_vec = 0;
  int n_bad = 0;

  // model: absolute writeback cycle per tag and set of cycles whose write port is taken
  int          cyc = 0;
  int          wb_time [64];
  bit          port_taken [0:4095];
  logic [31:0] m_sc = 0;

  function automatic vec_t mk(input logic v, input logic [5:0] s, input logic [5:0] t,
                              input logic us, input logic ut, input logic [1:0] rw_,
                              input logic [4:0] rd_, input logic [4:0] w_, input logic h,
                              input logic ei, input logic es, input logic [1:0] ec,
                              input logic [63:0] eb, input logic [31:0] esc);
    vec_t x;
    x.v = v; x.s = s; x.t = t; x.us = us; x.ut = ut; x.rw = rw_; x.rd = rd_; x.w = w_; x.h = h;
    x.ei = ei; x.es = es; x.ec = ec; x.eb = eb; x.esc = esc;
    return x;
  endfunction

  function automatic vec_t idle(input logic [63:0] eb, input logic [31:0] esc);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb, esc);
  endfunction

  function automatic bit mbusy(input logic [5:0] t);
    return t != 6'd0 && cyc < wb_time[t];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) wb_time[i] = 0;
    for (int i = 0; i < 4096; i++) port_taken[i] = 0;
    m_sc = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    dec_valid = x.v; rs = x.s; rt = x.t; use_s = x.us; use_t = x.ut;
    rw = x.rw; rd = x.rd; wait_time = x.w; hold = x.h;
  endtask

  // one pipeline cycle: drive after the edge, compare on the falling edge, then advance the model
  task automatic step(input vec_t x);
    logic [5:0]  dest;
    bit          wr, raw, waw, prt, haz, e_issue, e_stall;
    logic [1:0]  e_cause;
    logic [63:0] e_mask;
    @(posedge clk);
    #1;
    drive(x);
    @(negedge clk);
    dest    = {x.rw == 2'b10, x.rd};
    wr      = x.v && (x.rw == 2'b01 || x.rw == 2'b10) && dest != 6'd0;
    raw     = (x.us && mbusy(x.s)) || (x.ut && mbusy(x.t));
    waw     = wr && mbusy(dest);
    prt     = wr && port_taken[cyc + 1 + int'(x.w)];
    haz     = raw || waw || prt;
    e_stall = x.v && haz;
    e_issue = x.v && !haz && !x.h;
    e_cause = !x.v ? 2'b00 : raw ? 2'b01 : waw ? 2'b10 : prt ? 2'b11 : 2'b00;
    e_mask  = '0;
    for (int i = 0; i < 64; i++) e_mask[i] = mbusy(6'(i));
    chk("issue", 64'(issue), 64'(e_issue));
    chk("stall", 64'(stall), 64'(e_stall));
    chk("stall_cause", 64'(stall_cause), 64'(e_cause));
    chk("busy_mask", busy_mask, e_mask);
    chk("stall_cycles", 64'(stall_cycles), 64'(m_sc));
    if (e_issue && wr) begin
      wb_time[dest] = cyc + 1 + int'(x.w);
      port_taken[cyc + 1 + int'(x.w)] = 1;
    end
    if (e_stall) m_sc++;
    cyc++;
  endtask

  vec_t tbl[$];

  function automatic logic [5:0] rtag();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
  endfunction

  initial begin
    vec_t x;
    model_clear();
    // directed sequence, one row per cycle from a clean reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 0, 1, 3, 0, 0, 0, 1, 1, B2, 0));
    tbl.push_back(mk(1, 2, 0, 1, 0, 1, 3, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(idle(0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 3, 5, 0, 1, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 6'h23, 0, 1, 2, 4, 5, 0, 0, 1, 1, B35, 32'(1 + i)));
    tbl.push_back(mk(1, 0, 6'h23, 0, 1, 2, 4, 5, 0, 1, 0, 0, 0, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 3, 5, 0, 1, 0, 0, B36, 6));
    for (int i = 0; i < 4; i++) tbl.push_back(idle(B35 | B36, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 3, B35, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 3, 5, 0, 1, 0, 0, 0, 7));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 2, 3, 1, 0, 0, 1, 2, B35, 32'(7 + i)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 3, 1, 0, 1, 0, 0, 0, 12));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, B35, 12));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 12));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 7, 2, 1, 0, 0, 0, 0, 12));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 7, 2, 0, 1, 0, 0, 0, 12));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy_mask", busy_mask, 64'd0);
    chk("reset stall_cycles", 64'(stall_cycles), 64'd0);
    chk("reset issue", 64'(issue), 64'd0);
    rstn = 1;

    foreach (tbl[i]) begin
      step(tbl[i]);
      chk("tbl issue", 64'(issue), 64'(tbl[i].ei));
      chk("tbl stall", 64'(stall), 64'(tbl[i].es));
      chk("tbl cause", 64'(stall_cause), 64'(tbl[i].ec));
      chk("tbl busy", busy_mask, tbl[i].eb);
      chk("tbl stall_cycles", 64'(stall_cycles), 64'(tbl[i].esc));
    end

    // reset in the middle of an FADD f3 countdown (cnt=3) with its port slot still reserved
    step(mk(1, 0, 0, 0, 0, 2, 3, 5, 0, 1, 0, 0, 0, 0));
    repeat (3) step(idle(0, 0));
    chk("pre-reset f3 busy", 64'(busy_mask[35]), 64'd1);
    rstn = 0;
    #1;
    chk("async reset busy_mask", busy_mask, 64'd0);
    chk("async reset stall_cycles", 64'(stall_cycles), 64'd0);
    drive(mk(1, 0, 6'h23, 0, 1, 2, 4, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("in-reset issue", 64'(issue), 64'd1);
    chk("in-reset stall", 64'(stall), 64'd0);
    drive(idle(0, 0));
    model_clear();
    @(posedge clk);
    #1;
    rstn = 1;
    step(mk(1, 0, 6'h23, 0, 1, 2, 4, 0, 0, 0, 0, 0, 0, 0));
    chk("post-reset dependent issue", 64'(issue), 64'd1);

    // random traffic over a small tag set to provoke every hazard kind
    for (int i = 0; i < 600; i++) begin
      x = idle(0, 0);
      x.v  = $urandom_range(0, 4) != 0;
      x.s  = rtag();
      x.t  = rtag();
      x.us = 1'($urandom_range(0, 1));
      x.ut = 1'($urandom_range(0, 1));
      x.rw = 2'($urandom_range(0, 3));
      x.rd = 5'($urandom_range(0, 3));
      x.w  = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      x.h  = $urandom_range(0, 9) == 0;
      step(x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
